// File: rtl/pmips_pkg.sv
// Shared definitions for the PMIPS fetch unit: default widths and the
// instruction-buffer entry layout.
package pmips_pkg;

   localparam int ADDR_W_DEF  = 16;
   localparam int INSTR_W_DEF = 17;

   typedef struct packed {
      logic [INSTR_W_DEF-1:0] instr;
      logic [ADDR_W_DEF-1:0]  pcplus;
   } fetch_entry_t;

endpackage

// File: rtl/pmips_fifo.sv
// Synchronous FIFO with flush and occupancy count. DEPTH must be a power of 2
// so the read/write pointers wrap naturally.
module pmips_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 33
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Flush wins over both push and pop; popping an empty buffer is ignored.
   assign do_push = push & ~flush;
   assign do_pop  = pop & ~flush & (count != '0);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pmips_fetch_unit.sv
// PMIPS instruction fetch: PC register, single-outstanding-per-cycle request
// with slot reservation, and an instruction buffer feeding decode.
module pmips_fetch_unit
   import pmips_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                INSTR_W  = INSTR_W_DEF,
   parameter int                DEPTH    = 4,
   parameter int                PC_STEP  = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                       clock,
   input  logic                       reset,
   output logic [ADDR_W-1:0]          imemaddr,
   output logic                       imemreq,
   input  logic                       imemready,
   input  logic [INSTR_W-1:0]         imemrdata,
   output logic                       ifid_valid,
   output logic [INSTR_W-1:0]         ifid_instr,
   output logic [ADDR_W-1:0]          ifid_pcplus,
   input  logic                       id_stall,
   input  logic                       redirect,
   input  logic [ADDR_W-1:0]          redirect_pc,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

   localparam int                CW      = $clog2(DEPTH+1);
   localparam int                EW      = INSTR_W + ADDR_W;
   localparam logic [CW:0]       DEPTH_V = DEPTH[CW:0];
   localparam logic [ADDR_W-1:0] STEP    = PC_STEP[ADDR_W-1:0];

   logic [ADDR_W-1:0] pc;
   logic              inflight;
   logic [ADDR_W-1:0] inflight_pcplus;
   logic [CW:0]       reserved;
   logic              accept;
   logic              push;
   logic              pop;
   logic [EW-1:0]     head;

   // Every outstanding response already owns a buffer slot, so a push can
   // never find the buffer full.
   assign reserved = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
   assign imemreq  = reset & ~redirect & (reserved < DEPTH_V);
   assign imemaddr = pc;
   assign accept   = imemreq & imemready;

   assign push = inflight & ~redirect;
   assign pop  = ifid_valid & ~id_stall & ~redirect;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc       <= RESET_PC;
         inflight <= 1'b0;
      end else if (redirect) begin
         pc       <= redirect_pc;
         inflight <= 1'b0;
      end else begin
         inflight <= accept;
         if (accept) pc <= pc + STEP;
      end
   end

   always_ff @(posedge clock) begin
      if (accept) inflight_pcplus <= pc + STEP;
   end

   pmips_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .flush (redirect),
      .push  (push),
      .wdata ({imemrdata, inflight_pcplus}),
      .pop   (pop),
      .rdata (head),
      .count (fifo_count)
   );

   // Buffer storage is not reset, so the head is masked while empty.
   assign ifid_valid  = (fifo_count != '0);
   assign ifid_instr  = ifid_valid ? head[EW-1:ADDR_W] : '0;
   assign ifid_pcplus = ifid_valid ? head[ADDR_W-1:0]  : '0;

endmodule

// File: tb/tb_pmips_fetch_unit.sv
// Directed bench for pmips_fetch_unit: a cycle table for streaming, stall,
// backpressure and redirect, plus sequences for wrap, double redirect and reset.
module tb_pmips_fetch_unit;
   import pmips_pkg::*;

   logic        clock;
   logic        reset;
   logic [15:0] imemaddr;
   logic        imemreq;
   logic        imemready;
   logic [16:0] imemrdata;
   logic        ifid_valid;
   logic [16:0] ifid_instr;
   logic [15:0] ifid_pcplus;
   logic        id_stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [2:0]  fifo_count;

   int total;
   int passed;

   pmips_fetch_unit dut (
      .clock       (clock),
      .reset       (reset),
      .imemaddr    (imemaddr),
      .imemreq     (imemreq),
      .imemready   (imemready),
      .imemrdata   (imemrdata),
      .ifid_valid  (ifid_valid),
      .ifid_instr  (ifid_instr),
      .ifid_pcplus (ifid_pcplus),
      .id_stall    (id_stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .fifo_count  (fifo_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [16:0] instr_of(input logic [15:0] a);
      return {1'b1, a ^ 16'h5A5A};
   endfunction

   // Memory: returns data one cycle after acceptance, junk otherwise.
   always @(posedge clock) begin
      imemrdata <= (imemreq && imemready) ? instr_of(imemaddr) : 17'h1FFFF;
   end

   typedef struct packed {
      logic        rdy;
      logic        stall;
      logic        redir;
      logic [15:0] rpc;
      logic        req;
      logic [15:0] addr;
      logic [2:0]  cnt;
      logic [15:0] head;
   } vec_t;

   vec_t tbl [20];

   function automatic vec_t v(input logic rdy, input logic stall, input logic redir,
                              input logic [15:0] rpc, input logic req,
                              input logic [15:0] addr, input logic [2:0] cnt,
                              input logic [15:0] head);
      vec_t r;
      r.rdy = rdy; r.stall = stall; r.redir = redir; r.rpc = rpc;
      r.req = req; r.addr = addr; r.cnt = cnt; r.head = head;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_head(input string tag, input logic [2:0] cnt, input logic [15:0] head);
      fetch_entry_t e;
      if (cnt != 3'd0) begin
         e.instr  = instr_of(head);
         e.pcplus = head + 16'd2;
      end else begin
         e = '0;
      end
      chk({tag, " count"}, 32'(fifo_count), 32'(cnt));
      chk({tag, " valid"}, 32'(ifid_valid), 32'(cnt != 3'd0));
      chk({tag, " pcplus"}, 32'(ifid_pcplus), 32'(e.pcplus));
      chk({tag, " instr"}, 32'(ifid_instr), 32'(e.instr));
   endtask

   initial begin
      total  = 0;
      passed = 0;
      reset = 1'b0;
      imemready = 1'b0;
      id_stall = 1'b0;
      redirect = 1'b0;
      redirect_pc = 16'h0;

      tbl[0]  = v(1,0,0,16'h0000, 1,16'h0000,3'd0,16'h0000);
      tbl[1]  = v(1,0,0,16'h0000, 1,16'h0002,3'd0,16'h0000);
      tbl[2]  = v(1,0,0,16'h0000, 1,16'h0004,3'd1,16'h0000);
      tbl[3]  = v(1,1,0,16'h0000, 1,16'h0006,3'd1,16'h0002);
      tbl[4]  = v(1,1,0,16'h0000, 1,16'h0008,3'd2,16'h0002);
      tbl[5]  = v(1,1,0,16'h0000, 0,16'h000A,3'd3,16'h0002);
      tbl[6]  = v(1,1,0,16'h0000, 0,16'h000A,3'd4,16'h0002);
      tbl[7]  = v(1,1,0,16'h0000, 0,16'h000A,3'd4,16'h0002);
      tbl[8]  = v(1,0,0,16'h0000, 0,16'h000A,3'd4,16'h0002);
      tbl[9]  = v(1,0,0,16'h0000, 1,16'h000A,3'd3,16'h0004);
      tbl[10] = v(1,0,0,16'h0000, 1,16'h000C,3'd2,16'h0006);
      tbl[11] = v(0,0,0,16'h0000, 1,16'h000E,3'd2,16'h0008);
      tbl[12] = v(0,1,0,16'h0000, 1,16'h000E,3'd2,16'h000A);
      tbl[13] = v(0,1,0,16'h0000, 1,16'h000E,3'd2,16'h000A);
      tbl[14] = v(1,1,0,16'h0000, 1,16'h000E,3'd2,16'h000A);
      tbl[15] = v(1,1,0,16'h0000, 1,16'h0010,3'd2,16'h000A);
      tbl[16] = v(1,0,1,16'h0040, 0,16'h0012,3'd3,16'h000A);
      tbl[17] = v(1,0,0,16'h0000, 1,16'h0040,3'd0,16'h0000);
      tbl[18] = v(1,0,0,16'h0000, 1,16'h0042,3'd0,16'h0000);
      tbl[19] = v(1,0,0,16'h0000, 1,16'h0044,3'd1,16'h0040);

      // Reset state with memory ready
      imemready = 1'b1;
      #2;
      chk("rst req", 32'(imemreq), 32'd0);
      chk("rst addr", 32'(imemaddr), 32'h0);
      chk_head("rst", 3'd0, 16'h0);

      @(posedge clock);
      #1;
      reset = 1'b1;

      for (int i = 0; i < 20; i++) begin
         imemready   = tbl[i].rdy;
         id_stall    = tbl[i].stall;
         redirect    = tbl[i].redir;
         redirect_pc = tbl[i].rpc;
         #1;
         chk($sformatf("v%0d req", i), 32'(imemreq), 32'(tbl[i].req));
         chk($sformatf("v%0d addr", i), 32'(imemaddr), 32'(tbl[i].addr));
         chk_head($sformatf("v%0d", i), tbl[i].cnt, tbl[i].head);
         cyc();
      end

      // PC wrap: redirect to 0xFFFE, accept, next address is 0x0000
      imemready = 1'b1; id_stall = 1'b0;
      redirect = 1'b1; redirect_pc = 16'hFFFE;
      #1; chk("wrap redir req", 32'(imemreq), 32'd0);
      cyc(); redirect = 1'b0; #1;
      chk("wrap addr0", 32'(imemaddr), 32'hFFFE);
      chk("wrap req", 32'(imemreq), 32'd1);
      cyc(); #1;
      chk("wrap addr1", 32'(imemaddr), 32'h0000);
      chk_head("wrap t+2", 3'd0, 16'h0);
      cyc(); #1;
      chk_head("wrap t+3", 3'd1, 16'hFFFE);

      // Back-to-back redirects: the second target wins
      cyc(); redirect = 1'b1; redirect_pc = 16'h0100;
      cyc(); redirect_pc = 16'h0200;
      cyc(); redirect = 1'b0; #1;
      chk("b2b addr", 32'(imemaddr), 32'h0200);
      chk_head("b2b t+1", 3'd0, 16'h0);
      cyc(); #1;
      chk("b2b addr+1", 32'(imemaddr), 32'h0202);
      cyc(); #1;
      chk_head("b2b t+3", 3'd1, 16'h0200);

      // Reset with a fetch in flight, released before the response cycle ends
      cyc(); redirect = 1'b1; redirect_pc = 16'h0080;
      cyc(); redirect = 1'b0; id_stall = 1'b1; #1;
      chk("mid req", 32'(imemreq), 32'd1);
      chk("mid addr", 32'(imemaddr), 32'h0080);
      cyc();
      reset = 1'b0;
      #1;
      chk("mid rst req", 32'(imemreq), 32'd0);
      chk("mid rst addr", 32'(imemaddr), 32'h0);
      chk_head("mid rst", 3'd0, 16'h0);
      reset = 1'b1; id_stall = 1'b0;
      #1;
      chk("post rst req", 32'(imemreq), 32'd1);
      chk("post rst addr", 32'(imemaddr), 32'h0);
      cyc(); #1;
      chk_head("post rst t+1", 3'd0, 16'h0);
      cyc(); #1;
      chk_head("post rst t+2", 3'd1, 16'h0000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
